alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the ALU operand/result interface. Accepts one decoded RV32IM
//  integer instruction per handshake from decode and maps opcode/funct3/funct7 to the
//  5-bit ALU op code. Selects operands (rs1/rs2/imm/pc/shamt), drives them to the ALU,
//  waits out its registered latency and returns the tagged result on a writeback handshake.
// PARAMETERS
//  ALU_LATENCY  1  cycles alu_op/alu_in1/alu_in2 are held before the result is sampled
//  DIV_LATENCY  1  hold cycles for op codes 24/26/28/30 (multicycle divider path); >=1
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   synchronous reset, active-high
//  in_valid     in   1   decoded instruction valid
//  in_ready     out  1   block can accept (high only in IDLE)
//  in_opcode    in   7   instr[6:0]
//  in_funct3    in   3   instr[14:12]
//  in_funct7    in   7   instr[31:25]
//  in_rs1_val   in   32  rs1 value
//  in_rs2_val   in   32  rs2 value
//  in_imm       in   32  sign-extended I-imm, or U-imm already shifted <<12
//  in_pc        in   32  instruction PC
//  in_rd        in   5   destination tag
//  alu_op       out  5   op code to ALU
//  alu_in1      out  32  ALU operand 1
//  alu_in2      out  32  ALU operand 2
//  alu_result   in   32  registered ALU output
//  wb_valid     out  1   result valid
//  wb_ready     in   1   writeback accepts
//  wb_data      out  32  result
//  wb_rd        out  5   destination tag
//  wb_err       out  1   illegal encoding, wb_data=0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; wb_valid=0; wb_err=0; alu_op, alu_in1, alu_in2,
//   wb_data and wb_rd =0. All outputs are registered except in_ready (=state==IDLE).
//  Decode -> op code: ADD/ADDI/LUI/AUIPC 0; SUB 1; SLL/SLLI 2; XOR/XORI 3;
//   SRL/SRLI 4; SRA/SRAI 5; OR/ORI 6; AND/ANDI 7; SLT/SLTI/SLTU/SLTIU 8;
//   MULH 16; MULHSU 17; MULHU 18; MUL 22; DIV 24; DIVU 26; REM 28; REMU 30.
//  Operands: OP in1=rs1, in2=rs2. OP-IMM in1=rs1, in2=imm. Shift-imm in2={27'b0,imm[4:0]}.
//   LUI in1=0, in2=imm. AUIPC in1=pc, in2=imm.
//  Legal encodings: opcodes 0110011/0010011/0110111/0010111 only. funct7 must be 0000000,
//   0100000 (SUB/SRA/SRAI only) or 0000001 (OP only). Every other combination is illegal.
//  FSM: IDLE -accept-> ISSUE(hold L cycles; L=DIV_LATENCY for div/rem, else ALU_LATENCY)
//   -> CAPTURE (wb_data<=alu_result at cycle end) -> RESP (wb_valid=1) -wb_ready-> IDLE.
//   Illegal encoding: IDLE -accept-> RESP with wb_err=1, wb_data=0; ALU is not driven.
//  Latency: accept at cycle 0 -> wb_valid at cycle L+2 (3 for L=1); illegal -> cycle 1.
//  alu_op/alu_in1/alu_in2 load at accept and hold stable until the next accept.
//  RESP: wb_data/wb_rd/wb_err hold until wb_ready. No new accept before IDLE.
//   Throughput: 1 op per L+3 cycles with wb_ready tied high.
//  in_valid while busy is ignored; decode must hold it until in_ready.
//  rst mid-op: abandon in-flight op, no wb_valid pulse, all outputs to reset values next cycle.
// CONFIGURATION
//  ALU_DIV0_FIXUP_EN defined: op 24/26/28/30 with rs2==0 skip ISSUE. RESP next cycle with
//   DIV/DIVU=32'hFFFFFFFF, REM/REMU=rs1. DIV with rs1=32'h80000000 and rs2=-1 is the same
//   bypass, giving DIV=32'h80000000, REM=0.
//  ALU_DIV0_FIXUP_EN undefined: these operands go through the ALU normally and wb_data is
//   whatever alu_result returns.
// TESTING
//  ADDI rs1=5 imm=-7, wb_ready=1 -> alu_op=0, in2=FFFFFFF9; wb_valid at cycle 3, data=FFFFFFFE
//  SRAI rs1=80000000 imm=0x404 -> alu_op=5, in2=4; wb_data=F8000000
//  AUIPC pc=1000 imm=00002000 -> in1=1000; wb_data=00003000; wb_rd echoes in_rd
//  DIV rs1=7 rs2=0, macro on -> wb_data=FFFFFFFF at cycle 1; macro off -> ALU value, cycle L+2
//  OP funct7=0100000 funct3=XOR -> wb_err=1, wb_data=0 at cycle 1; alu_op unchanged
//  wb_ready low 4 cycles during RESP -> wb_* stable, in_ready=0; rst in ISSUE -> no wb_valid

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the ALU operand/result interface. Decodes one RV32IM
//   integer instruction per handshake into a 5-bit ALU op code and its operands.
//   It holds the operands on the ALU for the configured latency, then samples the
//   result and returns it with the destination tag on a writeback handshake.
//   Illegal encodings bypass the ALU and return wb_err=1 with wb_data=0.
//
//   Optional feature macro: ALU_DIV0_FIXUP_EN. When it is defined, divide/remainder
//   by zero and signed-overflow divide are answered directly without using the ALU.
//
// Ports
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   in_valid / in_ready       decoded-instruction handshake (ready only when idle)
//   in_opcode/funct3/funct7   instruction fields
//   in_rs1_val/rs2_val/imm/pc operand sources; in_rd destination tag
//   alu_op/alu_in1/alu_in2    registered ALU request, held until the next accept
//   alu_result                registered ALU output
//   wb_valid / wb_ready       result handshake; wb_data, wb_rd, wb_err held until taken
module alu_issue_ctrl #(
    parameter int ALU_LATENCY = 1,
    parameter int DIV_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_pc,
    input  logic [4:0]  in_rd,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_err
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam int MAXL = (ALU_LATENCY > DIV_LATENCY) ? ALU_LATENCY : DIV_LATENCY;
    localparam int CW   = (MAXL < 2) ? 1 : $clog2(MAXL);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          dec_ill, dec_div, fix_hit;
    logic [4:0]    dec_op;
    logic [31:0]   dec_in1, dec_in2, fix_data;

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // Instruction decode. funct7 is only checked where it selects the operation
    // (OP and the shift-immediates). Elsewhere it carries immediate bits.
    always_comb begin
        dec_ill = 1'b0;
        dec_op  = 5'd0;
        dec_in1 = in_rs1_val;
        dec_in2 = in_rs2_val;
        case (in_opcode)
            OPC_OP: begin
                if (in_funct7 == F7_BASE) begin
                    case (in_funct3)
                        3'd0:    dec_op = 5'd0;
                        3'd1:    dec_op = 5'd2;
                        3'd2,
                        3'd3:    dec_op = 5'd8;
                        3'd4:    dec_op = 5'd3;
                        3'd5:    dec_op = 5'd4;
                        3'd6:    dec_op = 5'd6;
                        default: dec_op = 5'd7;
                    endcase
                end else if (in_funct7 == F7_ALT) begin
                    if (in_funct3 == 3'd0)      dec_op = 5'd1;
                    else if (in_funct3 == 3'd5) dec_op = 5'd5;
                    else                        dec_ill = 1'b1;
                end else if (in_funct7 == F7_MULDIV) begin
                    case (in_funct3)
                        3'd0:    dec_op = 5'd22;
                        3'd1:    dec_op = 5'd16;
                        3'd2:    dec_op = 5'd17;
                        3'd3:    dec_op = 5'd18;
                        3'd4:    dec_op = 5'd24;
                        3'd5:    dec_op = 5'd26;
                        3'd6:    dec_op = 5'd28;
                        default: dec_op = 5'd30;
                    endcase
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                dec_in2 = in_imm;
                case (in_funct3)
                    3'd0:    dec_op = 5'd0;
                    3'd2,
                    3'd3:    dec_op = 5'd8;
                    3'd4:    dec_op = 5'd3;
                    3'd6:    dec_op = 5'd6;
                    3'd7:    dec_op = 5'd7;
                    3'd1: begin
                        dec_in2 = {27'b0, in_imm[4:0]};
                        dec_op  = 5'd2;
                        dec_ill = (in_funct7 != F7_BASE);
                    end
                    default: begin
                        dec_in2 = {27'b0, in_imm[4:0]};
                        if (in_funct7 == F7_BASE)     dec_op = 5'd4;
                        else if (in_funct7 == F7_ALT) dec_op = 5'd5;
                        else                          dec_ill = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_in1 = 32'd0;
                dec_in2 = in_imm;
            end
            OPC_AUIPC: begin
                dec_in1 = in_pc;
                dec_in2 = in_imm;
            end
            default: dec_ill = 1'b1;
        endcase
        // Div/rem codes 24/26/28/30 are the only ones with op[4:3]=2'b11.
        dec_div = !dec_ill && dec_op[4] && dec_op[3];
    end

`ifdef ALU_DIV0_FIXUP_EN
    // Answer the divide corner cases here. op[2] separates REM/REMU from DIV/DIVU.
    always_comb begin
        fix_hit  = 1'b0;
        fix_data = 32'd0;
        if (dec_div) begin
            if (in_rs2_val == 32'd0) begin
                fix_hit  = 1'b1;
                fix_data = dec_op[2] ? in_rs1_val : 32'hFFFF_FFFF;
            end else if (!dec_op[1] && in_rs1_val == 32'h8000_0000 &&
                         in_rs2_val == 32'hFFFF_FFFF) begin
                fix_hit  = 1'b1;
                fix_data = dec_op[2] ? 32'd0 : 32'h8000_0000;
            end
        end
    end
`else
    assign fix_hit  = 1'b0;
    assign fix_data = 32'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (dec_ill || fix_hit) ? RESP : ISSUE;
            ISSUE:   if (cnt == '0) state_nxt = CAPTURE;
            CAPTURE: state_nxt = RESP;
            default: if (wb_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            alu_op   <= 5'd0;
            alu_in1  <= 32'd0;
            alu_in2  <= 32'd0;
            wb_valid <= 1'b0;
            wb_data  <= 32'd0;
            wb_rd    <= 5'd0;
            wb_err   <= 1'b0;
        end else begin
            if (accept) begin
                wb_rd  <= in_rd;
                wb_err <= dec_ill;
                if (dec_ill) begin
                    // Illegal encodings do not disturb the ALU request registers.
                    wb_data  <= 32'd0;
                    wb_valid <= 1'b1;
                end else begin
                    alu_op  <= dec_op;
                    alu_in1 <= dec_in1;
                    alu_in2 <= dec_in2;
                    cnt     <= dec_div ? CW'(DIV_LATENCY - 1) : CW'(ALU_LATENCY - 1);
                    if (fix_hit) begin
                        wb_data  <= fix_data;
                        wb_valid <= 1'b1;
                    end
                end
            end
            if (state == ISSUE && cnt != '0) cnt <= cnt - 1'b1;
            if (state == CAPTURE) begin
                wb_data  <= alu_result;
                wb_valid <= 1'b1;
            end
            if (state == RESP && wb_ready) wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    localparam int ALU_LAT = 1;
    localparam int DIV_LAT = 3;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [6:0]  in_funct7 = '0;
    logic [31:0] in_rs1_val = '0, in_rs2_val = '0, in_imm = '0, in_pc = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  alu_op;
    logic [31:0] alu_in1, alu_in2;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;

    int n_chk = 0;
    int n_pass = 0;
    logic [4:0]  last_op = '0;
    logic [31:0] last_a = '0, last_b = '0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ALU_LATENCY(ALU_LAT), .DIV_LATENCY(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_pc(in_pc), .in_rd(in_rd), .alu_op(alu_op), .alu_in1(alu_in1),
        .alu_in2(alu_in2), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd), .wb_err(wb_err)
    );

    // Behavioural ALU with one register stage. Unguarded divide corners return
    // marker values so the non-fixup path is distinguishable.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0] pu;
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return a ^ b;
            5'd4:  return a >> b[4:0];
            5'd5:  return $signed(a) >>> b[4:0];
            5'd6:  return a | b;
            5'd7:  return a & b;
            5'd8:  return {31'b0, $signed(a) < $signed(b)};
            5'd16: begin ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return ps[63:32]; end
            5'd17: begin ps = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return ps[63:32]; end
            5'd18: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            5'd22: return a * b;
            5'd24, 5'd28: begin
                if (b == 0) return 32'hDEAD_BEEF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'hBAD0_BAD0;
                return (op == 5'd24) ? $signed(a) / $signed(b) : $signed(a) % $signed(b);
            end
            5'd26: return (b == 0) ? 32'hDEAD_BEEF : a / b;
            5'd30: return (b == 0) ? 32'hDEAD_BEEF : a % b;
            default: return 32'd0;
        endcase
    endfunction

    always_ff @(posedge clk) alu_result <= alu_fn(alu_op, alu_in1, alu_in2);

    // Reference decode from the ISA tables: op code, operands and legality.
    function automatic void predict(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                    input logic [31:0] rs1, input logic [31:0] rs2,
                                    input logic [31:0] imm, input logic [31:0] pc,
                                    output bit ill, output logic [4:0] op,
                                    output logic [31:0] a, output logic [31:0] b);
        logic [4:0] base_t [8];
        logic [4:0] mul_t [8];
        base_t = '{5'd0, 5'd2, 5'd8, 5'd8, 5'd3, 5'd4, 5'd6, 5'd7};
        mul_t  = '{5'd22, 5'd16, 5'd17, 5'd18, 5'd24, 5'd26, 5'd28, 5'd30};
        ill = 1; op = 0; a = rs1; b = rs2;
        if (opc == OP) begin
            if (f7 == 7'h00) begin ill = 0; op = base_t[f3]; end
            else if (f7 == 7'h20 && f3 == 3'd0) begin ill = 0; op = 5'd1; end
            else if (f7 == 7'h20 && f3 == 3'd5) begin ill = 0; op = 5'd5; end
            else if (f7 == 7'h01) begin ill = 0; op = mul_t[f3]; end
        end else if (opc == OPIMM) begin
            b = imm;
            if (f3 == 3'd1 || f3 == 3'd5) begin
                b = {27'b0, imm[4:0]};
                if (f7 == 7'h00) begin ill = 0; op = base_t[f3]; end
                else if (f3 == 3'd5 && f7 == 7'h20) begin ill = 0; op = 5'd5; end
            end else begin
                ill = 0; op = base_t[f3];
            end
        end else if (opc == LUI) begin
            ill = 0; a = 0; b = imm;
        end else if (opc == AUIPC) begin
            ill = 0; a = pc; b = imm;
        end
    endfunction

    // One transaction from IDLE: accept, operand check, latency, payload, optional
    // wb_ready stall, release. Starts and ends at a negedge.
    task automatic run_op(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                          input int stall);
        bit ill, fix;
        logic [4:0] op;
        logic [31:0] a, b, exp_d;
        int exp_lat, cyc;
        predict(opc, f3, f7, rs1, rs2, imm, pc, ill, op, a, b);
        fix = 0;
        exp_d = 32'd0;
`ifdef ALU_DIV0_FIXUP_EN
        if (!ill && op >= 5'd24) begin
            if (rs2 == 0) begin
                fix = 1; exp_d = (op == 5'd24 || op == 5'd26) ? 32'hFFFF_FFFF : rs1;
            end else if ((op == 5'd24 || op == 5'd28) && rs1 == 32'h8000_0000 && rs2 == 32'hFFFF_FFFF) begin
                fix = 1; exp_d = (op == 5'd24) ? 32'h8000_0000 : 32'd0;
            end
        end
`endif
        if (!ill && !fix) exp_d = alu_fn(op, a, b);
        exp_lat = (ill || fix) ? 1 : ((op >= 5'd24) ? DIV_LAT : ALU_LAT) + 2;

        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL %s ready_idle: got %b want 1", nm, in_ready);
        else n_pass++;
        in_valid = 1; in_opcode = opc; in_funct3 = f3; in_funct7 = f7;
        in_rs1_val = rs1; in_rs2_val = rs2; in_imm = imm; in_pc = pc; in_rd = rd;
        wb_ready = (stall == 0);
        @(posedge clk); @(negedge clk);
        in_valid = 0; in_opcode = 7'($urandom); in_rs1_val = $urandom; in_rs2_val = $urandom;
        in_imm = $urandom; in_rd = 5'($urandom);
        cyc = 1;
        if (!ill) begin last_op = op; last_a = a; last_b = b; end
        n_chk++;
        if ({alu_op, alu_in1, alu_in2} !== {last_op, last_a, last_b})
            $display("FAIL %s alu_req: got %0d/%h/%h want %0d/%h/%h", nm, alu_op, alu_in1, alu_in2, last_op, last_a, last_b);
        else n_pass++;
        while (!wb_valid && cyc < 40) begin @(negedge clk); cyc++; end
        n_chk++;
        if (cyc !== exp_lat) $display("FAIL %s latency: got %0d want %0d", nm, cyc, exp_lat);
        else n_pass++;
        n_chk++;
        if ({wb_data, wb_rd, wb_err} !== {exp_d, rd, ill})
            $display("FAIL %s wb: got %h/%0d/%b want %h/%0d/%b", nm, wb_data, wb_rd, wb_err, exp_d, rd, ill);
        else n_pass++;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            n_chk++;
            if ({wb_valid, in_ready, wb_data, wb_rd, wb_err} !== {2'b10, exp_d, rd, ill})
                $display("FAIL %s stall%0d: got v=%b r=%b %h/%0d/%b want v=1 r=0 %h/%0d/%b",
                         nm, s, wb_valid, in_ready, wb_data, wb_rd, wb_err, exp_d, rd, ill);
            else n_pass++;
        end
        wb_ready = 1;
        @(posedge clk); @(negedge clk);
        n_chk++;
        if ({wb_valid, in_ready} !== 2'b01) $display("FAIL %s release: got v=%b r=%b want v=0 r=1", nm, wb_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({in_ready, wb_valid, wb_err, alu_op, alu_in1, alu_in2, wb_data, wb_rd} !== {3'b100, 5'd0, 96'd0, 5'd0})
            $display("FAIL reset_state: got r=%b v=%b e=%b op=%0d %h %h %h rd=%0d want r=1 rest 0",
                     in_ready, wb_valid, wb_err, alu_op, alu_in1, alu_in2, wb_data, wb_rd);
        else n_pass++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op("addi",     OPIMM, 3'd0, 7'h7F, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 5'd3, 0);
        run_op("srai",     OPIMM, 3'd5, 7'h20, 32'h8000_0000, 32'd0, 32'h0000_0404, 32'd0, 5'd4, 0);
        run_op("auipc",    AUIPC, 3'd0, 7'h00, 32'd0, 32'd0, 32'h0000_2000, 32'h1000, 5'd17, 0);
        run_op("lui",      LUI,   3'd2, 7'h55, 32'hFFFF, 32'd0, 32'hABCD_E000, 32'h40, 5'd9, 0);
        run_op("sub",      OP,    3'd0, 7'h20, 32'd3, 32'd10, 32'd0, 32'd0, 5'd1, 0);
        run_op("mulhu",    OP,    3'd3, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2, 0);
        run_op("div0",     OP,    3'd4, 7'h01, 32'd7, 32'd0, 32'd0, 32'd0, 5'd5, 0);
        run_op("remu0",    OP,    3'd7, 7'h01, 32'd7, 32'd0, 32'd0, 32'd0, 5'd6, 0);
        run_op("div_ovf",  OP,    3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd7, 0);
        run_op("rem_ovf",  OP,    3'd6, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd8, 0);
        run_op("div",      OP,    3'd4, 7'h01, 32'hFFFF_FFF0, 32'd3, 32'd0, 32'd0, 5'd10, 0);
        run_op("ill_xor",  OP,    3'd4, 7'h20, 32'd1, 32'd2, 32'd0, 32'd0, 5'd11, 0);
        run_op("ill_slli", OPIMM, 3'd1, 7'h01, 32'd1, 32'd0, 32'h0000_0023, 32'd0, 5'd12, 0);
        run_op("ill_opc",  7'b1100011, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 32'd0, 5'd13, 0);
    endtask

    task automatic test_stall();
        run_op("stall_add", OP, 3'd0, 7'h00, 32'h1111_1111, 32'h2222_2222, 32'd0, 32'd0, 5'd21, 4);
        run_op("stall_ill", OP, 3'd1, 7'h20, 32'd0, 32'd0, 32'd0, 32'd0, 5'd22, 4);
    endtask

    task automatic test_random();
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [31:0] rs1, rs2, imm;
        logic [6:0] f7_t [4];
        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            f3 = 3'($urandom);
            rs1 = $urandom; rs2 = $urandom;
            f7_t = '{7'h00, 7'h20, 7'h01, 7'($urandom)};
            f7 = f7_t[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) rs2 = 0;
            if ($urandom_range(0, 5) == 0) begin rs1 = 32'h8000_0000; rs2 = 32'hFFFF_FFFF; end
            imm = {{20{f7[6]}}, f7, 5'($urandom)};
            if (r <= 3) opc = OP;
            else if (r <= 6) begin
                opc = OPIMM;
                if (f3 != 3'd1 && f3 != 3'd5) begin
                    imm = {{20{imm[11]}}, 12'($urandom)};
                    f7 = imm[11:5];
                end
            end else if (r <= 8) begin
                opc = (r == 7) ? LUI : AUIPC;
                imm = $urandom & 32'hFFFF_F000;
                f7 = imm[31:25];
            end else opc = 7'($urandom);
            run_op($sformatf("rnd%0d", i), opc, f3, f7, rs1, rs2, imm, $urandom, 5'($urandom), $urandom_range(0, 2));
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0;
        in_opcode = OP; in_funct3 = 3'd0; in_funct7 = 7'h00;
        in_rs1_val = 32'd1; in_rs2_val = 32'd2; in_rd = 5'd30;
        in_valid = 1; wb_ready = 1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) acc++;
            @(negedge clk);
        end
        in_valid = 0;
        n_chk++;
        if (acc !== 5) $display("FAIL back_to_back accepts: got %0d want 5", acc);
        else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        in_opcode = OP; in_funct3 = 3'd4; in_funct7 = 7'h01;
        in_rs1_val = 32'd100; in_rs2_val = 32'd7; in_rd = 5'd19;
        in_valid = 1;
        @(posedge clk); @(negedge clk);
        in_valid = 0; rst = 1;
        @(posedge clk); @(negedge clk);
        rst = 0;
        n_chk++;
        if ({in_ready, wb_valid, wb_err, alu_op, alu_in1, alu_in2, wb_data, wb_rd} !== {3'b100, 5'd0, 96'd0, 5'd0})
            $display("FAIL mid_reset_state: got r=%b v=%b e=%b op=%0d %h %h %h rd=%0d want r=1 rest 0",
                     in_ready, wb_valid, wb_err, alu_op, alu_in1, alu_in2, wb_data, wb_rd);
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (wb_valid) seen++;
            @(negedge clk);
        end
        n_chk++;
        if (seen !== 0) $display("FAIL mid_reset_no_wb: got %0d valid cycles want 0", seen);
        else n_pass++;
        last_op = 0; last_a = 0; last_b = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        run_op("post_rst", OPIMM, 3'd7, 7'h00, 32'hF0F0_F0F0, 32'd0, 32'h0000_00FF, 32'd0, 5'd31, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
